// File: rtl/riscv32ima_lsu_wback.sv
// riscv32ima_lsu_wback
//  Consumer end of the ALU-stage output handshake. Each accepted instruction is
//  completed here: LOAD/STORE go out on the data memory port, result-producing
//  ops are written straight back to the register file, and AMOs or malformed or
//  misaligned memory ops raise a one-cycle exception pulse.
//
//  Ports
//   clk, nrst            clock, synchronous active-low reset
//   alu_valid/alu_ready  handshake from the ALU stage
//   alu_opcode           major opcode
//   alu_func3_opcode     func3 (access size and sign)
//   alu_src_addr         rs2 index, carried for trace only
//   alu_dst_addr         rd index
//   alu_mem_addr         effective byte address for LOAD/STORE
//   alu_data             store data or rd result
//   dmem_*               data memory request / grant / response port
//   wback_reg_*          register file write port (one-cycle strobe)
//   lsu_exc, lsu_exc_addr  exception pulse and faulting address
//
//  All outputs are registered; alu_ready mirrors "state is IDLE" one edge late
//  so that it is 0 while in reset.

module riscv32ima_lsu_wback #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 32,
    parameter int OPCODE_WIDTH   = 7,
    parameter int FUNC3_WIDTH    = 3
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [OPCODE_WIDTH-1:0]   alu_opcode,
    input  logic [FUNC3_WIDTH-1:0]    alu_func3_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] alu_src_addr,
    input  logic [REG_ADDR_WIDTH-1:0] alu_dst_addr,
    input  logic [ADDR_WIDTH-1:0]     alu_mem_addr,
    input  logic [REG_DATA_WIDTH-1:0] alu_data,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [ADDR_WIDTH-1:0]     dmem_addr,
    output logic [3:0]                dmem_be,
    output logic [REG_DATA_WIDTH-1:0] dmem_wdata,
    input  logic                      dmem_gnt,
    input  logic                      dmem_rvalid,
    input  logic [REG_DATA_WIDTH-1:0] dmem_rdata,
    output logic                      wback_reg_wen,
    output logic [REG_ADDR_WIDTH-1:0] wback_reg_addr,
    output logic [REG_DATA_WIDTH-1:0] wback_reg_data,
    output logic                      lsu_exc,
    output logic [ADDR_WIDTH-1:0]     lsu_exc_addr
);

    localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD     = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_STORE    = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_AMO      = 7'b0101111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_OP       = 7'b0110011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_LUI      = 7'b0110111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_JALR     = 7'b1100111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_JAL      = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } state_t;

    state_t                      state;
    logic [FUNC3_WIDTH-1:0]      lat_func3;
    logic [REG_ADDR_WIDTH-1:0]   lat_rd;
    logic [1:0]                  lat_lane;

    logic                        accept;
    logic                        is_store;
    logic                        func3_ok;
    logic                        misaligned;
    logic [3:0]                  req_be;
    logic [REG_DATA_WIDTH-1:0]   req_wdata;
    logic [REG_DATA_WIDTH-1:0]   lane_data;
    logic [REG_DATA_WIDTH-1:0]   load_data;

    // rs2 index has no function here; folded into a sink so it is not flagged.
    logic                        unused_src;
    assign unused_src = ^alu_src_addr;

    assign accept   = alu_valid & alu_ready;
    assign is_store = (alu_opcode == OPC_STORE);

    // Decode of the memory access: legal func3, alignment, lanes and data.
    always_comb begin
        func3_ok   = 1'b0;
        misaligned = 1'b0;
        req_be     = 4'b1111;
        req_wdata  = alu_data;
        if (is_store)
            func3_ok = (alu_func3_opcode == 3'd0) || (alu_func3_opcode == 3'd1) ||
                       (alu_func3_opcode == 3'd2);
        else
            func3_ok = (alu_func3_opcode == 3'd0) || (alu_func3_opcode == 3'd1) ||
                       (alu_func3_opcode == 3'd2) || (alu_func3_opcode == 3'd4) ||
                       (alu_func3_opcode == 3'd5);
        case (alu_func3_opcode[1:0])
            2'd0: begin
                req_be    = 4'b0001 << alu_mem_addr[1:0];
                req_wdata = {4{alu_data[7:0]}};
            end
            2'd1: begin
                misaligned = alu_mem_addr[0];
                req_be     = 4'b0011 << alu_mem_addr[1:0];
                req_wdata  = {2{alu_data[15:0]}};
            end
            default: begin
                misaligned = (alu_mem_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Lane selection and extension of the returned read word.
    always_comb begin
        lane_data = dmem_rdata >> {lat_lane, 3'b000};
        load_data = lane_data;
        case (lat_func3)
            3'd0:    load_data = {{24{lane_data[7]}}, lane_data[7:0]};
            3'd4:    load_data = {24'd0, lane_data[7:0]};
            3'd1:    load_data = {{16{lane_data[15]}}, lane_data[15:0]};
            3'd5:    load_data = {16'd0, lane_data[15:0]};
            default: load_data = lane_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state          <= IDLE;
            alu_ready      <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_be        <= '0;
            dmem_wdata     <= '0;
            wback_reg_wen  <= 1'b0;
            wback_reg_addr <= '0;
            wback_reg_data <= '0;
            lsu_exc        <= 1'b0;
            lsu_exc_addr   <= '0;
            lat_func3      <= '0;
            lat_rd         <= '0;
            lat_lane       <= '0;
        end else begin
            wback_reg_wen <= 1'b0;
            lsu_exc       <= 1'b0;
            case (state)
                IDLE: begin
                    alu_ready <= 1'b1;
                    if (accept) begin
                        case (alu_opcode)
                            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                                wback_reg_wen  <= (alu_dst_addr != '0);
                                wback_reg_addr <= alu_dst_addr;
                                wback_reg_data <= alu_data;
                            end
                            OPC_AMO: begin
                                lsu_exc      <= 1'b1;
                                lsu_exc_addr <= alu_mem_addr;
                            end
                            OPC_LOAD, OPC_STORE: begin
                                if (!func3_ok || misaligned) begin
                                    lsu_exc      <= 1'b1;
                                    lsu_exc_addr <= alu_mem_addr;
                                end else begin
                                    state      <= REQ;
                                    alu_ready  <= 1'b0;
                                    dmem_req   <= 1'b1;
                                    dmem_we    <= is_store;
                                    dmem_addr  <= {alu_mem_addr[ADDR_WIDTH-1:2], 2'b00};
                                    dmem_be    <= req_be;
                                    dmem_wdata <= req_wdata;
                                    lat_func3  <= alu_func3_opcode;
                                    lat_rd     <= alu_dst_addr;
                                    lat_lane   <= alu_mem_addr[1:0];
                                end
                            end
                            // BRANCH, MISC_MEM, SYSTEM and unknown opcodes retire silently.
                            OPC_MISC_MEM: ;
                            default: ;
                        endcase
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            state     <= IDLE;
                            alu_ready <= 1'b1;
                        end else begin
                            state <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (dmem_rvalid) begin
                        wback_reg_wen  <= (lat_rd != '0);
                        wback_reg_addr <= lat_rd;
                        wback_reg_data <= load_data;
                        state          <= IDLE;
                        alu_ready      <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    alu_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv32ima_lsu_wback.sv
// tb_riscv32ima_lsu_wback
//  Directed bench for riscv32ima_lsu_wback: a vector table of single-accept
//  ops (write-back, silent retire, exceptions) followed by hand-written
//  multi-cycle load/store, back-to-back and reset-in-flight sequences.

module tb_riscv32ima_lsu_wback;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_AMO      = 7'b0101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    logic        clk;
    logic        nrst;
    logic        alu_valid;
    logic        alu_ready;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_func3_opcode;
    logic [4:0]  alu_src_addr;
    logic [4:0]  alu_dst_addr;
    logic [31:0] alu_mem_addr;
    logic [31:0] alu_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wback_reg_wen;
    logic [4:0]  wback_reg_addr;
    logic [31:0] wback_reg_data;
    logic        lsu_exc;
    logic [31:0] lsu_exc_addr;

    int checks;
    int failures;

    riscv32ima_lsu_wback dut (
        .clk              (clk),
        .nrst             (nrst),
        .alu_valid        (alu_valid),
        .alu_ready        (alu_ready),
        .alu_opcode       (alu_opcode),
        .alu_func3_opcode (alu_func3_opcode),
        .alu_src_addr     (alu_src_addr),
        .alu_dst_addr     (alu_dst_addr),
        .alu_mem_addr     (alu_mem_addr),
        .alu_data         (alu_data),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_gnt         (dmem_gnt),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .wback_reg_wen    (wback_reg_wen),
        .wback_reg_addr   (wback_reg_addr),
        .wback_reg_data   (wback_reg_data),
        .lsu_exc          (lsu_exc),
        .lsu_exc_addr     (lsu_exc_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        string       name;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_wen;
        logic        exp_exc;
    } vec_t;

    vec_t vecs[17];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Presents one instruction for a single accepting edge; returns at the
    // negedge after that edge with alu_valid already dropped.
    task automatic applyStimulus(input logic [6:0] opcode, input logic [2:0] func3,
                                 input logic [4:0] rd, input logic [31:0] addr,
                                 input logic [31:0] data);
        @(negedge clk);
        alu_valid        = 1'b1;
        alu_opcode       = opcode;
        alu_func3_opcode = func3;
        alu_src_addr     = 5'd17;
        alu_dst_addr     = rd;
        alu_mem_addr     = addr;
        alu_data         = data;
        @(negedge clk);
        alu_valid = 1'b0;
    endtask

    task automatic doLoad(input string name, input logic [2:0] func3, input logic [4:0] rd,
                          input logic [31:0] addr, input int gnt_delay,
                          input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_data);
        applyStimulus(OPC_LOAD, func3, rd, addr, 32'h0);
        for (int i = 0; i <= gnt_delay; i++) begin
            checkOutput({name, " req"}, {31'd0, dmem_req}, 32'd1);
            checkOutput({name, " addr"}, dmem_addr, {addr[31:2], 2'b00});
            checkOutput({name, " be"}, {28'd0, dmem_be}, {28'd0, exp_be});
            checkOutput({name, " we"}, {31'd0, dmem_we}, 32'd0);
            checkOutput({name, " ready"}, {31'd0, alu_ready}, 32'd0);
            if (i == gnt_delay) dmem_gnt = 1'b1;
            @(negedge clk);
        end
        dmem_gnt = 1'b0;
        checkOutput({name, " req drop"}, {31'd0, dmem_req}, 32'd0);
        checkOutput({name, " rsp ready"}, {31'd0, alu_ready}, 32'd0);
        checkOutput({name, " early wen"}, {31'd0, wback_reg_wen}, 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        checkOutput({name, " wen"}, {31'd0, wback_reg_wen}, {31'd0, rd != 5'd0});
        if (rd != 5'd0) begin
            checkOutput({name, " wb addr"}, {27'd0, wback_reg_addr}, {27'd0, rd});
            checkOutput({name, " wb data"}, wback_reg_data, exp_data);
        end
        checkOutput({name, " ready back"}, {31'd0, alu_ready}, 32'd1);
        @(negedge clk);
        checkOutput({name, " wen pulse"}, {31'd0, wback_reg_wen}, 32'd0);
    endtask

    task automatic doStore(input string name, input logic [2:0] func3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input int gnt_delay, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata);
        applyStimulus(OPC_STORE, func3, 5'd0, addr, data);
        for (int i = 0; i <= gnt_delay; i++) begin
            checkOutput({name, " req"}, {31'd0, dmem_req}, 32'd1);
            checkOutput({name, " we"}, {31'd0, dmem_we}, 32'd1);
            checkOutput({name, " addr"}, dmem_addr, {addr[31:2], 2'b00});
            checkOutput({name, " be"}, {28'd0, dmem_be}, {28'd0, exp_be});
            checkOutput({name, " wdata"}, dmem_wdata, exp_wdata);
            checkOutput({name, " ready"}, {31'd0, alu_ready}, 32'd0);
            if (i == gnt_delay) dmem_gnt = 1'b1;
            @(negedge clk);
        end
        dmem_gnt = 1'b0;
        checkOutput({name, " req drop"}, {31'd0, dmem_req}, 32'd0);
        checkOutput({name, " ready back"}, {31'd0, alu_ready}, 32'd1);
        checkOutput({name, " no wen"}, {31'd0, wback_reg_wen}, 32'd0);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        nrst             = 1'b0;
        alu_valid        = 1'b0;
        alu_opcode       = 7'd0;
        alu_func3_opcode = 3'd0;
        alu_src_addr     = 5'd0;
        alu_dst_addr     = 5'd0;
        alu_mem_addr     = 32'h0;
        alu_data         = 32'h0;
        dmem_gnt         = 1'b0;
        dmem_rvalid      = 1'b0;
        dmem_rdata       = 32'h0;

        vecs[0]  = '{"OP rd5",        OPC_OP,       3'd0, 5'd5,  32'h0,   32'h0000_1234, 1'b1, 1'b0};
        vecs[1]  = '{"OP_IMM rd31",   OPC_OP_IMM,   3'd0, 5'd31, 32'h0,   32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2]  = '{"LUI rd1",       OPC_LUI,      3'd0, 5'd1,  32'h0,   32'hABCD_E000, 1'b1, 1'b0};
        vecs[3]  = '{"AUIPC rd2",     OPC_AUIPC,    3'd0, 5'd2,  32'h0,   32'h8000_0004, 1'b1, 1'b0};
        vecs[4]  = '{"JAL rd3",       OPC_JAL,      3'd0, 5'd3,  32'h0,   32'h0000_0104, 1'b1, 1'b0};
        vecs[5]  = '{"JALR rd4",      OPC_JALR,     3'd0, 5'd4,  32'h0,   32'h0000_0208, 1'b1, 1'b0};
        vecs[6]  = '{"OP rd0",        OPC_OP,       3'd0, 5'd0,  32'h0,   32'h0000_DEAD, 1'b0, 1'b0};
        vecs[7]  = '{"BRANCH",        OPC_BRANCH,   3'd1, 5'd6,  32'h40,  32'h1111_1111, 1'b0, 1'b0};
        vecs[8]  = '{"SYSTEM",        OPC_SYSTEM,   3'd0, 5'd7,  32'h0,   32'h2222_2222, 1'b0, 1'b0};
        vecs[9]  = '{"MISC_MEM",      OPC_MISC_MEM, 3'd0, 5'd8,  32'h0,   32'h3333_3333, 1'b0, 1'b0};
        vecs[10] = '{"AMO",           OPC_AMO,      3'd2, 5'd9,  32'h300, 32'h4444_4444, 1'b0, 1'b1};
        vecs[11] = '{"LH misaligned", OPC_LOAD,     3'd1, 5'd10, 32'h101, 32'h0,         1'b0, 1'b1};
        vecs[12] = '{"LW misaligned", OPC_LOAD,     3'd2, 5'd11, 32'h102, 32'h0,         1'b0, 1'b1};
        vecs[13] = '{"LOAD func3=3",  OPC_LOAD,     3'd3, 5'd12, 32'h100, 32'h0,         1'b0, 1'b1};
        vecs[14] = '{"SW misaligned", OPC_STORE,    3'd2, 5'd0,  32'h001, 32'h5555_5555, 1'b0, 1'b1};
        vecs[15] = '{"STORE func3=4", OPC_STORE,    3'd4, 5'd0,  32'h010, 32'h6666_6666, 1'b0, 1'b1};
        vecs[16] = '{"LHU misaligned",OPC_LOAD,     3'd5, 5'd13, 32'h003, 32'h0,         1'b0, 1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset ready", {31'd0, alu_ready}, 32'd0);
        checkOutput("reset req", {31'd0, dmem_req}, 32'd0);
        checkOutput("reset wen", {31'd0, wback_reg_wen}, 32'd0);
        checkOutput("reset exc", {31'd0, lsu_exc}, 32'd0);
        checkOutput("reset be", {28'd0, dmem_be}, 32'd0);
        nrst = 1'b1;
        @(negedge clk);
        checkOutput("ready after reset", {31'd0, alu_ready}, 32'd1);

        // Single-accept table
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].opcode, vecs[i].func3, vecs[i].rd, vecs[i].addr, vecs[i].data);
            checkOutput({vecs[i].name, " wen"}, {31'd0, wback_reg_wen}, {31'd0, vecs[i].exp_wen});
            checkOutput({vecs[i].name, " exc"}, {31'd0, lsu_exc}, {31'd0, vecs[i].exp_exc});
            checkOutput({vecs[i].name, " req"}, {31'd0, dmem_req}, 32'd0);
            checkOutput({vecs[i].name, " ready"}, {31'd0, alu_ready}, 32'd1);
            if (vecs[i].exp_wen) begin
                checkOutput({vecs[i].name, " wb addr"}, {27'd0, wback_reg_addr}, {27'd0, vecs[i].rd});
                checkOutput({vecs[i].name, " wb data"}, wback_reg_data, vecs[i].data);
            end
            if (vecs[i].exp_exc)
                checkOutput({vecs[i].name, " exc addr"}, lsu_exc_addr, vecs[i].addr);
        end
        @(negedge clk);
        checkOutput("exc pulse", {31'd0, lsu_exc}, 32'd0);

        // Back-to-back ALU ops, one per clock
        alu_valid        = 1'b1;
        alu_opcode       = OPC_OP;
        alu_func3_opcode = 3'd0;
        alu_dst_addr     = 5'd10;
        alu_data         = 32'h0000_0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("b2b wen", {31'd0, wback_reg_wen}, 32'd1);
            checkOutput("b2b addr", {27'd0, wback_reg_addr}, 32'd10 + i);
            checkOutput("b2b data", wback_reg_data, 32'd1 + i);
            alu_dst_addr = alu_dst_addr + 5'd1;
            alu_data     = alu_data + 32'd1;
            if (i == 2) alu_valid = 1'b0;
        end
        @(negedge clk);
        checkOutput("b2b wen end", {31'd0, wback_reg_wen}, 32'd0);

        // Stores
        doStore("SB 0x103", 3'd0, 32'h0000_0103, 32'h0000_00A5, 0, 4'b1000, 32'hA5A5_A5A5);
        doStore("SH 0x102", 3'd1, 32'h0000_0102, 32'h1234_BEEF, 0, 4'b1100, 32'hBEEF_BEEF);
        doStore("SW 0x104", 3'd2, 32'h0000_0104, 32'hCAFE_F00D, 2, 4'b1111, 32'hCAFE_F00D);

        // Loads
        doLoad("LB 0x102",  3'd0, 5'd7,  32'h0000_0102, 0, 32'h0080_0000, 4'b0100, 32'hFFFF_FF80);
        doLoad("LBU 0x102", 3'd4, 5'd8,  32'h0000_0102, 0, 32'h0080_0000, 4'b0100, 32'h0000_0080);
        doLoad("LB 0x101",  3'd0, 5'd9,  32'h0000_0101, 1, 32'h1122_7F44, 4'b0010, 32'h0000_007F);
        doLoad("LH 0x102",  3'd1, 5'd14, 32'h0000_0102, 0, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
        doLoad("LHU 0x102", 3'd5, 5'd15, 32'h0000_0102, 0, 32'h8001_0000, 4'b1100, 32'h0000_8001);
        doLoad("LW gnt+3",  3'd2, 5'd16, 32'h0000_0204, 3, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        doLoad("LW rd0",    3'd2, 5'd0,  32'h0000_0208, 0, 32'h1234_5678, 4'b1111, 32'h0);

        // Reset while waiting for read data; the late rvalid must be ignored
        applyStimulus(OPC_LOAD, 3'd2, 5'd9, 32'h0000_0200, 32'h0);
        checkOutput("rst seq req", {31'd0, dmem_req}, 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        nrst     = 1'b0;
        @(negedge clk);
        checkOutput("rst seq ready", {31'd0, alu_ready}, 32'd0);
        checkOutput("rst seq req", {31'd0, dmem_req}, 32'd0);
        nrst        = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h9999_9999;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        checkOutput("late rvalid wen", {31'd0, wback_reg_wen}, 32'd0);
        checkOutput("late rvalid ready", {31'd0, alu_ready}, 32'd1);
        @(negedge clk);
        checkOutput("late rvalid wen2", {31'd0, wback_reg_wen}, 32'd0);
        applyStimulus(OPC_OP, 3'd0, 5'd21, 32'h0, 32'h0000_5A5A);
        checkOutput("post rst wen", {31'd0, wback_reg_wen}, 32'd1);
        checkOutput("post rst data", wback_reg_data, 32'h0000_5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
